data_bus_mmio: RTL and testbench
================================

Name: data_bus_mmio

Overview:
- Sits between the CPU data port and the data RAM. Forwards RAM-region accesses unchanged.
- Decodes a small memory-mapped I/O window holding a debug output latch, a free-running cycle counter, a halt request and a scratch register.
- Gives test programs a result/halt channel independent of register v0. Flags illegal data-side accesses.

Parameters:
- MMIO_BASE, 32'hFFFF_0000: base of the 64 KiB MMIO window, addresses MMIO_BASE..MMIO_BASE+16'hFFFF.
- ERR_READ_VALUE, 32'hDEAD_BEEF: value returned for erroneous or unmapped reads.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low reset
- data_address  input  32  CPU byte address
- data_write  input  1  CPU write strobe
- data_read  input  1  CPU read strobe
- data_writedata  input  32  CPU write data
- data_readdata  output  32  read data to CPU
- ram_address  output  32  to data RAM
- ram_write  output  1  to data RAM
- ram_read  output  1  to data RAM
- ram_writedata  output  32  to data RAM
- ram_readdata  input  32  from data RAM
- debug_out  output  32  last value written to DEBUG register
- debug_valid  output  1  one-cycle pulse after each DEBUG write
- cycle_count  output  32  current cycle counter
- halt_req  output  1  sticky halt request
- bus_error  output  1  sticky error flag
- err_address  output  32  address of first error

Behaviour:
- Decode (combinational):
  - hit_mmio = data_address[31:16] == MMIO_BASE[31:16]. Otherwise the access targets RAM.
  - MMIO offset = data_address[15:0]. Registers: 0x0 DEBUG, 0x4 CYCLE, 0x8 HALT, 0xC SCRATCH. All other offsets are unmapped.
- Error conditions:
  - data_address[1:0] != 0 with data_read or data_write asserted.
  - data_read and data_write asserted in the same cycle.
  - MMIO access to an unmapped offset.
- Any erroneous access:
  - suppresses its write entirely: ram_write=0 and no register update;
  - returns ERR_READ_VALUE on data_readdata;
  - sets bus_error at the next edge.
  - err_address captures data_address only when bus_error was 0 (first error wins).
- RAM path:
  - ram_address and ram_writedata mirror the CPU inputs.
  - ram_read/ram_write = CPU strobe AND !hit_mmio AND no error.
  - data_readdata = ram_readdata on non-error RAM reads, with RAM latency unchanged.
- MMIO reads are combinational, zero latency:
  - DEBUG returns debug_out.
  - CYCLE returns cycle_count.
  - HALT returns {31'b0, halt_req}.
  - SCRATCH returns the scratch register.
- data_readdata = 0 when neither strobe is asserted.
- MMIO writes take effect at the rising edge:
  - DEBUG: debug_out <= data_writedata; debug_valid=1 for exactly the following cycle. Back-to-back writes keep debug_valid high each cycle.
  - CYCLE: cycle_count <= 0. Takes priority over increment.
  - HALT: if data_writedata != 0, halt_req <= 1. Writing 0 has no effect. Only reset clears halt_req.
  - SCRATCH: full 32-bit store.
- Cycle counter:
  - Increments by 1 each edge while halt_req==0.
  - Saturates at 32'hFFFF_FFFF; no wrap.
  - Frozen from the edge after halt_req rises.
- Reset (async, active-low), mid-operation included: all outputs and registers cleared immediately.
  - debug_out, debug_valid, cycle_count, halt_req, bus_error, err_address and scratch all become 0.
  - RAM strobes follow the CPU inputs combinationally; reset does not gate them.
  - Counting resumes on the first edge after reset deasserts.

Optional Feature:
- Macro: DATA_BUS_STATS_EN.
- Defined:
  - Two extra read-only counters at offsets 0x10 RD_COUNT and 0x14 WR_COUNT.
  - They count non-error data-side reads and writes in both RAM and MMIO regions, saturating at 32'hFFFF_FFFF.
  - Writing either offset clears both counters.
  - Reset clears both.
- Undefined: no counters; offsets 0x10/0x14 are unmapped and raise bus_error.

Test Plan:
- Reset low for 2 cycles, then high; no accesses for 5 cycles -> all outputs 0 during reset; cycle_count reads 5 via CYCLE read.
- Write 0x1234_5678 to 0xFFFF_0000 -> debug_out=0x1234_5678 after the edge; debug_valid high for exactly one cycle; RAM sees no ram_write.
- RAM write of 0xCAFE_F00D to 0x0000_0040, then read -> ram_write asserted; read returns 0xCAFE_F00D; bus_error stays 0.
- Write 1 to 0xFFFF_0008 -> halt_req=1; cycle_count stops changing; a later write of 0 leaves halt_req=1.
- Read 0x0000_0042 (misaligned), then write to 0xFFFF_0020 (unmapped) -> first read returns 0xDEAD_BEEF; bus_error=1; err_address=0x0000_0042 unchanged by the second error; no write occurs.
- Write 0xFFFF_0004 while cycle_count=100; assert reset low mid-run -> counter reads 0 then 1 on following cycles; async reset clears halt_req, bus_error and scratch without waiting for a clock edge.

Source files
------------

// File: rtl/data_bus_mmio_if.sv
// CPU data-port bundle between the core (master) and the data-bus/MMIO decoder (slave).
interface data_bus_mmio_if;
    logic [31:0] data_address;
    logic        data_write;
    logic        data_read;
    logic [31:0] data_writedata;
    logic [31:0] data_readdata;

    modport master (
        output data_address,
        output data_write,
        output data_read,
        output data_writedata,
        input  data_readdata
    );

    modport slave (
        input  data_address,
        input  data_write,
        input  data_read,
        input  data_writedata,
        output data_readdata
    );
endinterface

// File: rtl/data_bus_mmio.sv
// Data-side bus splitter: forwards RAM accesses, decodes a 64 KiB MMIO window with debug/cycle/halt/scratch
// registers and flags illegal accesses. Define DATA_BUS_STATS_EN to add RD_COUNT/WR_COUNT access counters.
module data_bus_mmio #(
    parameter logic [31:0] MMIO_BASE      = 32'hFFFF_0000,
    parameter logic [31:0] ERR_READ_VALUE = 32'hDEAD_BEEF
) (
    input  logic                  clk,
    input  logic                  reset,
    data_bus_mmio_if.slave        cpu,
    output logic [31:0]           ram_address,
    output logic                  ram_write,
    output logic                  ram_read,
    output logic [31:0]           ram_writedata,
    input  logic [31:0]           ram_readdata,
    output logic [31:0]           debug_out,
    output logic                  debug_valid,
    output logic [31:0]           cycle_count,
    output logic                  halt_req,
    output logic                  bus_error,
    output logic [31:0]           err_address
);

    localparam logic [15:0] OFF_DEBUG   = 16'h0000;
    localparam logic [15:0] OFF_CYCLE   = 16'h0004;
    localparam logic [15:0] OFF_HALT    = 16'h0008;
    localparam logic [15:0] OFF_SCRATCH = 16'h000C;
`ifdef DATA_BUS_STATS_EN
    localparam logic [15:0] OFF_RDCNT   = 16'h0010;
    localparam logic [15:0] OFF_WRCNT   = 16'h0014;
`endif

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    logic        rd, wr, access, hit_mmio, mapped, err, rd_ok, wr_ok;
    logic [15:0] off;
    logic        sel_debug, sel_cycle, sel_halt, sel_scratch;
    logic [31:0] rdata;

    logic [31:0] debug_out_q,   debug_out_d;
    logic        debug_valid_q, debug_valid_d;
    logic [31:0] cycle_q,       cycle_d;
    logic        halt_q,        halt_d;
    logic [31:0] scratch_q,     scratch_d;
    logic        bus_error_q,   bus_error_d;
    logic [31:0] err_address_q, err_address_d;
`ifdef DATA_BUS_STATS_EN
    logic        sel_rdcnt, sel_wrcnt;
    logic [31:0] rd_cnt_q, rd_cnt_d;
    logic [31:0] wr_cnt_q, wr_cnt_d;
`endif

    assign rd       = cpu.data_read;
    assign wr       = cpu.data_write;
    assign access   = rd | wr;
    assign hit_mmio = (cpu.data_address[31:16] == MMIO_BASE[31:16]);
    assign off      = cpu.data_address[15:0];

    assign sel_debug   = hit_mmio && (off == OFF_DEBUG);
    assign sel_cycle   = hit_mmio && (off == OFF_CYCLE);
    assign sel_halt    = hit_mmio && (off == OFF_HALT);
    assign sel_scratch = hit_mmio && (off == OFF_SCRATCH);
`ifdef DATA_BUS_STATS_EN
    assign sel_rdcnt   = hit_mmio && (off == OFF_RDCNT);
    assign sel_wrcnt   = hit_mmio && (off == OFF_WRCNT);
    assign mapped      = sel_debug | sel_cycle | sel_halt | sel_scratch | sel_rdcnt | sel_wrcnt;
`else
    assign mapped      = sel_debug | sel_cycle | sel_halt | sel_scratch;
`endif

    // Misalignment, read+write collision and unmapped MMIO offsets all count as errors.
    assign err = (access && (cpu.data_address[1:0] != 2'b00))
               | (rd && wr)
               | (access && hit_mmio && !mapped);
    assign rd_ok = rd && !err;
    assign wr_ok = wr && !err;

    // RAM strobes are never gated by reset, only by decode and error.
    assign ram_address   = cpu.data_address;
    assign ram_writedata = cpu.data_writedata;
    assign ram_read      = rd && !hit_mmio && !err;
    assign ram_write     = wr && !hit_mmio && !err;

    always_comb begin
        rdata = 32'd0;
        if (err) begin
            rdata = ERR_READ_VALUE;
        end else if (rd) begin
            if (!hit_mmio)        rdata = ram_readdata;
            else if (sel_debug)   rdata = debug_out_q;
            else if (sel_cycle)   rdata = cycle_q;
            else if (sel_halt)    rdata = {31'd0, halt_q};
            else if (sel_scratch) rdata = scratch_q;
`ifdef DATA_BUS_STATS_EN
            else if (sel_rdcnt)   rdata = rd_cnt_q;
            else if (sel_wrcnt)   rdata = wr_cnt_q;
`endif
        end
    end
    assign cpu.data_readdata = rdata;

    always_comb begin
        debug_out_d   = debug_out_q;
        debug_valid_d = wr_ok && sel_debug;
        if (wr_ok && sel_debug) debug_out_d = cpu.data_writedata;

        // Counter clear wins over increment; halt freezes it from the edge after halt_req rises.
        cycle_d = halt_q ? cycle_q : sat_inc(cycle_q);
        if (wr_ok && sel_cycle) cycle_d = 32'd0;

        halt_d    = halt_q | (wr_ok && sel_halt && (cpu.data_writedata != 32'd0));
        scratch_d = (wr_ok && sel_scratch) ? cpu.data_writedata : scratch_q;

        bus_error_d   = bus_error_q | err;
        err_address_d = (err && !bus_error_q) ? cpu.data_address : err_address_q;

`ifdef DATA_BUS_STATS_EN
        rd_cnt_d = rd_ok ? sat_inc(rd_cnt_q) : rd_cnt_q;
        wr_cnt_d = wr_ok ? sat_inc(wr_cnt_q) : wr_cnt_q;
        if (wr_ok && (sel_rdcnt || sel_wrcnt)) begin
            rd_cnt_d = 32'd0;
            wr_cnt_d = 32'd0;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            debug_out_q   <= 32'd0;
            debug_valid_q <= 1'b0;
            cycle_q       <= 32'd0;
            halt_q        <= 1'b0;
            scratch_q     <= 32'd0;
            bus_error_q   <= 1'b0;
            err_address_q <= 32'd0;
`ifdef DATA_BUS_STATS_EN
            rd_cnt_q      <= 32'd0;
            wr_cnt_q      <= 32'd0;
`endif
        end else begin
            debug_out_q   <= debug_out_d;
            debug_valid_q <= debug_valid_d;
            cycle_q       <= cycle_d;
            halt_q        <= halt_d;
            scratch_q     <= scratch_d;
            bus_error_q   <= bus_error_d;
            err_address_q <= err_address_d;
`ifdef DATA_BUS_STATS_EN
            rd_cnt_q      <= rd_cnt_d;
            wr_cnt_q      <= wr_cnt_d;
`endif
        end
    end

    assign debug_out   = debug_out_q;
    assign debug_valid = debug_valid_q;
    assign cycle_count = cycle_q;
    assign halt_req    = halt_q;
    assign bus_error   = bus_error_q;
    assign err_address = err_address_q;

`ifndef DATA_BUS_STATS_EN
    logic unused_ok;
    assign unused_ok = rd_ok;
`endif

endmodule

// File: tb/tb_data_bus_mmio.sv
// Directed bench for data_bus_mmio: inputs change just after falling edges, outputs sampled 1 time unit later.
module tb_data_bus_mmio;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] ram_address, ram_writedata, ram_readdata;
    logic        ram_write, ram_read;
    logic [31:0] debug_out, cycle_count, err_address;
    logic        debug_valid, halt_req, bus_error;
    logic [31:0] mem [0:63];
    logic [31:0] snap;
    logic        found;
    int          total = 0;
    int          bad   = 0;

    data_bus_mmio_if cpu();

    data_bus_mmio dut (
        .clk          (clk),
        .reset        (reset),
        .cpu          (cpu.slave),
        .ram_address  (ram_address),
        .ram_write    (ram_write),
        .ram_read     (ram_read),
        .ram_writedata(ram_writedata),
        .ram_readdata (ram_readdata),
        .debug_out    (debug_out),
        .debug_valid  (debug_valid),
        .cycle_count  (cycle_count),
        .halt_req     (halt_req),
        .bus_error    (bus_error),
        .err_address  (err_address)
    );

    always #5 clk = ~clk;

    assign ram_readdata = mem[ram_address[7:2]];
    always @(posedge clk) if (ram_write) mem[ram_address[7:2]] <= ram_writedata;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic set_bus(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd);
        cpu.data_read      = rd;
        cpu.data_write     = wr;
        cpu.data_address   = a;
        cpu.data_writedata = wd;
        #1;
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd);
        @(negedge clk);
        set_bus(rd, wr, a, wd);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        set_bus(1'b0, 1'b0, 32'd0, 32'd0);
        #1;
        chk_eq("rst_debug_out", debug_out, 32'd0);
        chk_eq("rst_debug_valid", {31'd0, debug_valid}, 32'd0);
        chk_eq("rst_cycle", cycle_count, 32'd0);
        chk_eq("rst_halt", {31'd0, halt_req}, 32'd0);
        chk_eq("rst_bus_error", {31'd0, bus_error}, 32'd0);
        chk_eq("rst_err_addr", err_address, 32'd0);
        chk_eq("rst_rdata_idle", cpu.data_readdata, 32'd0);
        tick();
        tick();
        chk_eq("rst_cycle_held", cycle_count, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (5) @(posedge clk);

        // Five idle edges after reset release
        drive(1'b1, 1'b0, 32'hFFFF_0004, 32'd0);
        chk_eq("cycle_read_5", cpu.data_readdata, 32'd5);

        drive(1'b0, 1'b1, 32'hFFFF_0000, 32'h1234_5678);
        chk_eq("dbg_no_ram_wr", {31'd0, ram_write}, 32'd0);
        tick();
        chk_eq("dbg_out", debug_out, 32'h1234_5678);
        chk_eq("dbg_valid_hi", {31'd0, debug_valid}, 32'd1);
        drive(1'b0, 1'b0, 32'd0, 32'd0);
        tick();
        chk_eq("dbg_valid_lo", {31'd0, debug_valid}, 32'd0);
        chk_eq("dbg_out_hold", debug_out, 32'h1234_5678);

        drive(1'b0, 1'b1, 32'hFFFF_0000, 32'h0000_1111);
        tick();
        chk_eq("dbg_b2b_v1", {31'd0, debug_valid}, 32'd1);
        drive(1'b0, 1'b1, 32'hFFFF_0000, 32'h0000_2222);
        tick();
        chk_eq("dbg_b2b_v2", {31'd0, debug_valid}, 32'd1);
        chk_eq("dbg_b2b_out", debug_out, 32'h0000_2222);
        drive(1'b1, 1'b0, 32'hFFFF_0000, 32'd0);
        chk_eq("dbg_readback", cpu.data_readdata, 32'h0000_2222);
        tick();
        chk_eq("dbg_b2b_lo", {31'd0, debug_valid}, 32'd0);

        drive(1'b0, 1'b1, 32'h0000_0040, 32'hCAFE_F00D);
        chk_eq("ram_wr_strobe", {31'd0, ram_write}, 32'd1);
        chk_eq("ram_wr_addr", ram_address, 32'h0000_0040);
        chk_eq("ram_wr_data", ram_writedata, 32'hCAFE_F00D);
        tick();
        drive(1'b1, 1'b0, 32'h0000_0040, 32'd0);
        chk_eq("ram_rd_strobe", {31'd0, ram_read}, 32'd1);
        chk_eq("ram_rd_data", cpu.data_readdata, 32'hCAFE_F00D);
        drive(1'b0, 1'b0, 32'h0000_0040, 32'd0);
        chk_eq("idle_rdata", cpu.data_readdata, 32'd0);
        chk_eq("ram_no_err", {31'd0, bus_error}, 32'd0);

        drive(1'b0, 1'b1, 32'hFFFF_000C, 32'hA5A5_0F0F);
        tick();
        drive(1'b1, 1'b0, 32'hFFFF_000C, 32'd0);
        chk_eq("scratch_rd", cpu.data_readdata, 32'hA5A5_0F0F);
        chk_eq("scratch_no_ram", {31'd0, ram_read}, 32'd0);

        // Wait for the counter to reach 100, then clear it on that edge
        found = 1'b0;
        set_bus(1'b0, 1'b0, 32'd0, 32'd0);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (cycle_count == 32'd100) begin
                found = 1'b1;
                break;
            end
        end
        chk_eq("cycle_reach_100", {31'd0, found}, 32'd1);
        set_bus(1'b0, 1'b1, 32'hFFFF_0004, 32'hFFFF_FFFF);
        tick();
        chk_eq("cycle_clr_0", cycle_count, 32'd0);
        drive(1'b0, 1'b0, 32'd0, 32'd0);
        tick();
        chk_eq("cycle_after_1", cycle_count, 32'd1);

        drive(1'b0, 1'b1, 32'hFFFF_0008, 32'd0);
        tick();
        chk_eq("halt_wr0_noop", {31'd0, halt_req}, 32'd0);
        drive(1'b0, 1'b1, 32'hFFFF_0008, 32'd1);
        tick();
        chk_eq("halt_set", {31'd0, halt_req}, 32'd1);
        snap = cycle_count;
        drive(1'b0, 1'b0, 32'd0, 32'd0);
        tick();
        tick();
        tick();
        chk_eq("cycle_frozen", cycle_count, snap);
        drive(1'b1, 1'b0, 32'hFFFF_0008, 32'd0);
        chk_eq("halt_rd", cpu.data_readdata, 32'd1);
        drive(1'b0, 1'b1, 32'hFFFF_0008, 32'd0);
        tick();
        chk_eq("halt_sticky", {31'd0, halt_req}, 32'd1);

        drive(1'b1, 1'b0, 32'h0000_0042, 32'd0);
        chk_eq("mis_rd_val", cpu.data_readdata, 32'hDEAD_BEEF);
        chk_eq("mis_rd_no_ram", {31'd0, ram_read}, 32'd0);
        tick();
        chk_eq("err_flag", {31'd0, bus_error}, 32'd1);
        chk_eq("err_addr_first", err_address, 32'h0000_0042);
        drive(1'b0, 1'b1, 32'hFFFF_0020, 32'h0000_0055);
        chk_eq("unmap_no_ram_wr", {31'd0, ram_write}, 32'd0);
        chk_eq("unmap_rd_val", cpu.data_readdata, 32'hDEAD_BEEF);
        tick();
        chk_eq("err_addr_keep", err_address, 32'h0000_0042);
        drive(1'b1, 1'b1, 32'h0000_0044, 32'h0000_0077);
        chk_eq("rw_both_no_wr", {31'd0, ram_write}, 32'd0);
        chk_eq("rw_both_no_rd", {31'd0, ram_read}, 32'd0);
        chk_eq("rw_both_val", cpu.data_readdata, 32'hDEAD_BEEF);
        drive(1'b0, 1'b1, 32'h0000_0046, 32'h0000_0099);
        chk_eq("mis_wr_no_ram", {31'd0, ram_write}, 32'd0);
        drive(1'b0, 1'b1, 32'hFFFF_0002, 32'h0000_0BAD);
        tick();
        chk_eq("mis_dbg_no_upd", debug_out, 32'h0000_2222);
        chk_eq("mis_dbg_no_vld", {31'd0, debug_valid}, 32'd0);
`ifndef DATA_BUS_STATS_EN
        drive(1'b1, 1'b0, 32'hFFFF_0010, 32'd0);
        chk_eq("nostats_unmapped", cpu.data_readdata, 32'hDEAD_BEEF);
`endif

        // Asynchronous reset between edges
        drive(1'b0, 1'b0, 32'd0, 32'd0);
        #1;
        reset = 1'b0;
        #1;
        chk_eq("arst_halt", {31'd0, halt_req}, 32'd0);
        chk_eq("arst_bus_error", {31'd0, bus_error}, 32'd0);
        chk_eq("arst_err_addr", err_address, 32'd0);
        chk_eq("arst_debug_out", debug_out, 32'd0);
        chk_eq("arst_cycle", cycle_count, 32'd0);
        set_bus(1'b1, 1'b0, 32'hFFFF_000C, 32'd0);
        chk_eq("arst_scratch", cpu.data_readdata, 32'd0);
        set_bus(1'b1, 1'b0, 32'h0000_0040, 32'd0);
        chk_eq("arst_ram_rd_pass", {31'd0, ram_read}, 32'd1);
        tick();
        chk_eq("arst_cycle_held", cycle_count, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        set_bus(1'b0, 1'b0, 32'd0, 32'd0);
        tick();
        chk_eq("resume_cycle_1", cycle_count, 32'd1);
        tick();
        chk_eq("resume_cycle_2", cycle_count, 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
